// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings, status codes and the D pipeline register layout
package y86_pkg;
  localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7;
  localparam logic [3:0] ICALL = 4'h8, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;
  localparam int NREG = 15;
  localparam logic [3:0] RRSP = 4'h4, RNONE = 4'hF;
  typedef enum logic [1:0] {SAOK = 2'd0, SHLT = 2'd1, SADR = 2'd2, SINS = 2'd3} stat_t;
  typedef struct packed {
    stat_t       stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;
  localparam d_reg_t D_BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0, ra: RNONE, rb: RNONE, valc: 64'd0, valp: 64'd0};
endpackage

// File: rtl/regfile.sv
// regfile: 15x64 register file, two write ports (M wins on collision), two bypassed read ports
module regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  w_dste,
  input  logic [63:0] w_vale,
  input  logic [3:0]  w_dstm,
  input  logic [63:0] w_valm,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b
);
  logic [63:0] regs_q [NREG];
  logic [63:0] regs_d [NREG];
  always_comb begin
    regs_d = regs_q;
    if (w_dste != RNONE) regs_d[w_dste] = w_vale;
    if (w_dstm != RNONE) regs_d[w_dstm] = w_valm;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= (i == int'(RRSP)) ? RSP_INIT : 64'd0;
    end else begin
      regs_q <= regs_d;
    end
  end
  // Writeback data in flight this cycle is forwarded so decode sees it without waiting an edge
  assign val_a = (src_a == RNONE) ? 64'd0 : (src_a == w_dstm) ? w_valm :
                 (src_a == w_dste) ? w_vale : regs_q[src_a];
  assign val_b = (src_b == RNONE) ? 64'd0 : (src_b == w_dstm) ? w_valm :
                 (src_b == w_dste) ? w_vale : regs_q[src_b];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: F-to-D pipeline register, register file and operand/destination selection
module decode_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        f_imem_error,
  input  logic        f_func_error,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  output logic [1:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [63:0] D_valC,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB
);
  d_reg_t d_q, d_d, f_reg;
  logic [63:0] rf_a, rf_b;
  // A bad fetch address carries no usable instruction, so it enters as a nop with ADR status
  always_comb begin
    f_reg = '{stat: f_imem_error ? SADR : f_func_error ? SINS : (f_icode == IHALT) ? SHLT : SAOK,
              icode: f_imem_error ? INOP : f_icode,
              ifun: f_imem_error ? 4'h0 : f_ifun,
              ra: f_imem_error ? RNONE : f_rA,
              rb: f_imem_error ? RNONE : f_rB,
              valc: f_valC,
              valp: f_valP};
    d_d = D_stall ? d_q : D_bubble ? D_BUBBLE : f_reg;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= D_BUBBLE;
    else     d_q <= d_d;
  end
  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_valC  = d_q.valc;
  always_comb begin
    d_srcA = (d_q.icode inside {IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ}) ? d_q.ra :
             (d_q.icode inside {IRET, IPOPQ}) ? RRSP : RNONE;
    d_srcB = (d_q.icode inside {IRMMOVQ, IMRMOVQ, IOPQ}) ? d_q.rb :
             (d_q.icode inside {ICALL, IRET, IPUSHQ, IPOPQ}) ? RRSP : RNONE;
    d_dstE = (d_q.icode inside {IRRMOVQ, IIRMOVQ, IOPQ}) ? d_q.rb :
             (d_q.icode inside {ICALL, IRET, IPUSHQ, IPOPQ}) ? RRSP : RNONE;
    d_dstM = (d_q.icode inside {IMRMOVQ, IPOPQ}) ? d_q.ra : RNONE;
    d_valA = (d_q.icode inside {IJXX, ICALL}) ? d_q.valp : rf_a;
    d_valB = rf_b;
  end
  regfile #(.RSP_INIT(RSP_INIT)) u_regfile (
    .clk(clk), .rst(rst),
    .w_dste(W_dstE), .w_vale(W_valE), .w_dstm(W_dstM), .w_valm(W_valM),
    .src_a(d_srcA), .src_b(d_srcB), .val_a(rf_a), .val_b(rf_b)
  );
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined decode stage directly downstream of the fetch stage; consumes icode/ifun/rA/rB/valC/valP/imem_error/func_error.
- Contains the F-to-D pipeline register with stall/bubble control, the 15-entry 64-bit register file, and the source/destination selection logic.
- Writeback (W) ports write the register file.
- Produces valA/valB plus register IDs for the execute stage.

Parameters:
- RSP_INIT, 64'd0, reset value of register 4 (%rsp); all other registers reset to 0.
- NREG, 15, number of architectural registers; ID 4'hF = RNONE.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- f_icode  in  4  fetched icode.
- f_ifun  in  4  fetched ifun.
- f_rA  in  4  fetched rA.
- f_rB  in  4  fetched rB.
- f_valC  in  64  fetched constant.
- f_valP  in  64  fetched next PC.
- f_imem_error  in  1  fetch address error.
- f_func_error  in  1  fetch invalid-instruction error.
- D_stall  in  1  hold D register.
- D_bubble  in  1  load nop into D register.
- W_dstE  in  4  writeback E destination (F = none).
- W_valE  in  64  writeback E data.
- W_dstM  in  4  writeback M destination (F = none).
- W_valM  in  64  writeback M data.
- D_stat  out  2  registered status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- D_icode  out  4  registered icode.
- D_ifun  out  4  registered ifun.
- D_valC  out  64  registered valC.
- d_srcA  out  4  combinational source A ID.
- d_srcB  out  4  combinational source B ID.
- d_dstE  out  4  combinational E destination.
- d_dstM  out  4  combinational M destination.
- d_valA  out  64  operand A.
- d_valB  out  64  operand B.

Behaviour:
- Reset (async, rst=1): D register = bubble (icode 1, ifun 0, rA=rB=F, valC=valP=0, stat AOK); regs[4]=RSP_INIT, all other regs 0. Reset mid-operation discards any in-flight instruction.
- D register update on posedge, with priority stall > bubble > load:
  - D_stall=1: hold all fields.
  - else D_bubble=1: load bubble values.
  - else load f_* fields.
  - Stall and bubble together: stall wins.
- Stat encode at load, priority ADR > INS > HLT > AOK:
  - f_imem_error -> ADR; f_icode/ifun forced to nop fields and rA/rB to F.
  - else f_func_error -> INS.
  - else f_icode==0 -> HLT.
  - else AOK.
- Source/destination selection is combinational from D_icode (hex):
  - srcA = rA for 2,4,6,A; 4 for 9,B; else F.
  - srcB = rB for 4,5,6; 4 for 8,9,A,B; else F.
  - dstE = rB for 2,3,6; 4 for 8,9,A,B; else F. The cmov condition is resolved downstream.
  - dstM = rA for 5,B; else F.
- valA = D_valP for icode 7 or 8; else read(srcA). valB = read(srcB).
- read(id):
  - F returns 0.
  - Same-cycle bypass: if id==W_dstM, return W_valM; else if id==W_dstE, return W_valE; else regs[id].
- Register write on posedge, not gated by stall:
  - W_dstE!=F: regs[W_dstE] <= W_valE.
  - W_dstM!=F: regs[W_dstM] <= W_valM.
  - Both target the same register: valM wins (popq %rsp semantics).
  - Writes to F are ignored.
- Latency: f_* visible on D_* one cycle after the load edge; d_* are combinational off D_* and the register file.
- Decode of out-of-range icode (C-F) with stat INS: all IDs = F, valA=valB=0.

Decomposition:
- Shared package y86_pkg:
  - icode constants: IHALT..IPOPQ = 0..B.
  - RRSP=4, RNONE=F.
  - stat codes SAOK/SHLT/SADR/SINS.
  - Bubble field constants.
- One natural sub-module: regfile. It holds 15x64 storage with two write ports (M priority), two bypassed read ports, and async reset with RSP_INIT.
- decode_stage instantiates regfile plus the D register and selection logic.

Test Plan:
- Reset: rst=1 mid-stream -> D_icode=1, D_stat=0, d_valB=RSP_INIT on a pushq decode, all other regs read 0.
- Load OPq: write regs[2]=5 and regs[3]=7 via W ports, then fetch icode 6, rA=2, rB=3 -> next cycle d_srcA=2, d_srcB=3, d_dstE=3, d_valA=5, d_valB=7.
- Bypass: D holds rrmovq rA=1 while W_dstE=1, W_valE=64'hDEAD in the same cycle -> d_valA=64'hDEAD. The same cycle with W_dstM=1, W_valM=64'hBEEF also asserted -> d_valA=64'hBEEF. After the edge, regs[1]=BEEF.
- Stall/bubble: D_stall=1 for 2 cycles with new f_* -> D_* unchanged. D_stall=1 with D_bubble=1 -> hold. D_bubble=1 alone -> D_icode=1.
- Status: f_imem_error=1 -> D_stat=2. f_func_error=1 -> D_stat=3. f_icode=0 -> D_stat=1, all IDs F.
- call: f_icode=8, f_valP=64'h109 -> d_valA=64'h109, d_srcB=4, d_dstE=4, d_dstM=F.
